// File: rtl/ps2_digit_decoder.sv
// PS/2 set-2 scancode decoder for the digits 0..9: tracks held keys, queues make
// events in a small FIFO and presents the head on registered outputs.
module ps2_digit_decoder #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned KEYPAD_EN     = 1,
  parameter int unsigned REPEAT_FILTER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       dout_valid,
  output logic [3:0] dout,
  input  logic       dout_ready,
  output logic [9:0] held,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam bit          KP_ON = (KEYPAD_EN != 0);
  localparam bit          RF_ON = (REPEAT_FILTER != 0);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [9:0]    held_q, held_d;
  logic          overflow_q, overflow_d;
  logic          dout_valid_q, dout_valid_d;
  logic [3:0]    dout_q, dout_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    mem_q [FIFO_DEPTH];

  logic          main_hit_c, kp_hit_c, hit_c;
  logic [3:0]    main_dig_c, kp_dig_c, digit_c;
  logic [9:0]    digit_oh_c;
  logic          make_c, release_c;
  logic          push_c, pop_c, full_c, wr_en_c, ovf_set_c;
  logic [AW-1:0] rd_next_c;

  // Scancode lookup for the main row and the numeric keypad.
  always_comb begin
    main_hit_c = 1'b0;
    main_dig_c = 4'd0;
    kp_hit_c   = 1'b0;
    kp_dig_c   = 4'd0;
    case (code)
      8'h45: {main_hit_c, main_dig_c} = {1'b1, 4'd0};
      8'h16: {main_hit_c, main_dig_c} = {1'b1, 4'd1};
      8'h1E: {main_hit_c, main_dig_c} = {1'b1, 4'd2};
      8'h26: {main_hit_c, main_dig_c} = {1'b1, 4'd3};
      8'h25: {main_hit_c, main_dig_c} = {1'b1, 4'd4};
      8'h2E: {main_hit_c, main_dig_c} = {1'b1, 4'd5};
      8'h36: {main_hit_c, main_dig_c} = {1'b1, 4'd6};
      8'h3D: {main_hit_c, main_dig_c} = {1'b1, 4'd7};
      8'h3E: {main_hit_c, main_dig_c} = {1'b1, 4'd8};
      8'h46: {main_hit_c, main_dig_c} = {1'b1, 4'd9};
      default: ;
    endcase
    case (code)
      8'h70: {kp_hit_c, kp_dig_c} = {1'b1, 4'd0};
      8'h69: {kp_hit_c, kp_dig_c} = {1'b1, 4'd1};
      8'h72: {kp_hit_c, kp_dig_c} = {1'b1, 4'd2};
      8'h7A: {kp_hit_c, kp_dig_c} = {1'b1, 4'd3};
      8'h6B: {kp_hit_c, kp_dig_c} = {1'b1, 4'd4};
      8'h73: {kp_hit_c, kp_dig_c} = {1'b1, 4'd5};
      8'h74: {kp_hit_c, kp_dig_c} = {1'b1, 4'd6};
      8'h6C: {kp_hit_c, kp_dig_c} = {1'b1, 4'd7};
      8'h75: {kp_hit_c, kp_dig_c} = {1'b1, 4'd8};
      8'h7D: {kp_hit_c, kp_dig_c} = {1'b1, 4'd9};
      default: ;
    endcase
    hit_c      = main_hit_c | (KP_ON & kp_hit_c);
    digit_c    = main_hit_c ? main_dig_c : kp_dig_c;
    digit_oh_c = 10'd1 << digit_c;
  end

  // Prefix tracking: E0 marks an extended key, F0 marks a release.
  always_comb begin
    state_d   = state_q;
    make_c    = 1'b0;
    release_c = 1'b0;
    if (code_valid) begin
      case (state_q)
        IDLE: begin
          if (code == CODE_EXT) begin
            state_d = EXT;
          end else if (code == CODE_BRK) begin
            state_d = BRK;
          end else begin
            make_c = hit_c;
          end
        end
        EXT: begin
          if (code == CODE_BRK) begin
            state_d = EXT_BRK;
          end else if (code != CODE_EXT) begin
            state_d = IDLE;
          end
        end
        BRK: begin
          state_d   = IDLE;
          release_c = hit_c;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Held map, queue bookkeeping and the registered queue head.
  always_comb begin
    held_d       = held_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    push_c    = make_c & ~(RF_ON & |(held_q & digit_oh_c));
    pop_c     = dout_valid_q & dout_ready;
    full_c    = (count_q == CW'(FIFO_DEPTH));
    wr_en_c   = push_c & (~full_c | pop_c);
    ovf_set_c = push_c & full_c & ~pop_c;
    rd_next_c = rd_ptr_q + AW'(1);

    if (make_c) begin
      held_d = held_q | digit_oh_c;
    end
    if (release_c) begin
      held_d = held_q & ~digit_oh_c;
    end
    overflow_d = overflow_q | ovf_set_c;

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_next_c;
    end
    count_d = count_q + CW'(wr_en_c) - CW'(pop_c);

    // The head either advances to the next stored entry or to the byte being pushed.
    if (pop_c) begin
      if (count_q > CW'(1)) begin
        dout_d       = mem_q[rd_next_c];
        dout_valid_d = 1'b1;
      end else if (wr_en_c) begin
        dout_d       = digit_c;
        dout_valid_d = 1'b1;
      end else begin
        dout_d       = 4'd0;
        dout_valid_d = 1'b0;
      end
    end else if (!dout_valid_q && wr_en_c) begin
      dout_d       = digit_c;
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      held_q       <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= 4'd0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Queue storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= digit_c;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign held       = held_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_digit_decoder.sv
// Directed bench for ps2_digit_decoder: three parameter variants share one byte
// stream and are checked every cycle against a queue-based behavioural model.
module tb_ps2_digit_decoder;

  localparam int NI    = 3;
  localparam int DEPTH = 4;

  localparam logic [7:0] MAIN_MAP [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                           8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] KP_MAP   [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                           8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] code;
  logic       dout_ready;

  logic       dv [NI];
  logic [3:0] dq [NI];
  logic [9:0] hd [NI];
  logic       ov [NI];

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: no repeat filter; 2: keypad disabled.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    ps2_digit_decoder #(
      .FIFO_DEPTH   (DEPTH),
      .KEYPAD_EN    ((g == 2) ? 32'd0 : 32'd1),
      .REPEAT_FILTER((g == 1) ? 32'd0 : 32'd1)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .code_valid(code_valid),
      .code      (code),
      .dout_valid(dv[g]),
      .dout      (dq[g]),
      .dout_ready(dout_ready),
      .held      (hd[g]),
      .overflow  (ov[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  int       mq   [NI][$];
  bit [9:0] mheld[NI];
  bit       mext [NI];
  bit       mbrk [NI];
  bit       movf [NI];
  int       got  [NI][$];

  function automatic bit kp_of(int i);
    return i != 2;
  endfunction

  function automatic bit rf_of(int i);
    return i != 1;
  endfunction

  function automatic int digit_of(logic [7:0] c, bit kp);
    for (int k = 0; k < 10; k++) begin
      if (MAIN_MAP[k] == c) return k;
      if (kp && KP_MAP[k] == c) return k;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int d;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        mq[i].delete();
        mheld[i] = '0;
        mext[i]  = 1'b0;
        mbrk[i]  = 1'b0;
        movf[i]  = 1'b0;
      end else begin
        if (mq[i].size() > 0 && dout_ready) void'(mq[i].pop_front());
        if (code_valid) begin
          d = digit_of(code, kp_of(i));
          if (mext[i] && mbrk[i]) begin
            mext[i] = 1'b0;
            mbrk[i] = 1'b0;
          end else if (mbrk[i]) begin
            if (d >= 0) mheld[i][d] = 1'b0;
            mbrk[i] = 1'b0;
          end else if (mext[i]) begin
            if (code == 8'hF0) mbrk[i] = 1'b1;
            else if (code != 8'hE0) mext[i] = 1'b0;
          end else if (code == 8'hE0) begin
            mext[i] = 1'b1;
          end else if (code == 8'hF0) begin
            mbrk[i] = 1'b1;
          end else if (d >= 0) begin
            if (!(rf_of(i) && mheld[i][d])) begin
              mheld[i][d] = 1'b1;
              if (mq[i].size() < DEPTH) mq[i].push_back(d);
              else movf[i] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d.dout_valid", i), 32'(dv[i]), 32'(mq[i].size() > 0));
      if (mq[i].size() > 0) chk($sformatf("i%0d.dout", i), 32'(dq[i]), 32'(mq[i][0]));
      chk($sformatf("i%0d.held", i), 32'(hd[i]), 32'(mheld[i]));
      chk($sformatf("i%0d.overflow", i), 32'(ov[i]), 32'(movf[i]));
    end
  endtask

  // One clock: apply inputs at the falling edge, log accepted heads, check after the rise.
  task automatic cyc(bit cv, logic [7:0] c);
    code_valid = cv;
    code       = c;
    for (int i = 0; i < NI; i++) begin
      if (dv[i] === 1'b1 && dout_ready) got[i].push_back(int'(dq[i]));
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(logic [7:0] c);
    cyc(1'b1, c);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  task automatic chk_got(string nm, int i, int base, int e[$]);
    chk({nm, ".count"}, 32'(got[i].size() - base), 32'(e.size()));
    for (int k = 0; k < e.size(); k++) begin
      if (base + k < got[i].size()) chk($sformatf("%s.out%0d", nm, k), 32'(got[i][base + k]), 32'(e[k]));
    end
  endtask

  initial begin
    int b0, b1, b2;
    int e[$];

    reset      = 1'b1;
    code_valid = 1'b0;
    code       = 8'h00;
    dout_ready = 1'b1;
    @(negedge clk);
    idle(2);
    chk("rst.dout_valid", 32'(dv[0]), 32'd0);
    chk("rst.dout", 32'(dq[0]), 32'd0);
    chk("rst.held", 32'(hd[0]), 32'd0);
    chk("rst.overflow", 32'(ov[0]), 32'd0);
    reset = 1'b0;
    idle(1);

    // Press and release of digit 1.
    b0 = got[0].size();
    send(8'h16);
    chk("a.held_after_make", 32'(hd[0]), 32'h002);
    chk("a.first_latency", 32'(dv[0]), 32'd1);
    send(8'hF0);
    send(8'h16);
    chk("a.held_after_release", 32'(hd[0]), 32'h000);
    idle(2);
    e = '{1};
    chk_got("a.out", 0, b0, e);

    // Typematic repeats of digit 3, with and without filtering.
    b0 = got[0].size();
    b1 = got[1].size();
    send(8'h26); send(8'h26); send(8'h26); send(8'hF0); send(8'h26); send(8'h26);
    idle(3);
    e = '{3, 3};
    chk_got("b.rf1", 0, b0, e);
    e = '{3, 3, 3, 3};
    chk_got("b.rf0", 1, b1, e);
    send(8'hF0); send(8'h26);

    // Extended keypad codes are ignored; plain keypad code depends on KEYPAD_EN.
    b0 = got[0].size();
    b2 = got[2].size();
    send(8'hE0); send(8'h70); send(8'hE0); send(8'hF0); send(8'h70);
    idle(2);
    chk("c.ext_held", 32'(hd[0]), 32'h000);
    e = {};
    chk_got("c.ext_kp1", 0, b0, e);
    chk_got("c.ext_kp0", 2, b2, e);
    send(8'h70);
    idle(2);
    chk("c.kp_held_en", 32'(hd[0]), 32'h001);
    chk("c.kp_held_dis", 32'(hd[2]), 32'h000);
    e = '{0};
    chk_got("c.kp1", 0, b0, e);
    e = {};
    chk_got("c.kp0", 2, b2, e);
    send(8'hF0); send(8'h70);

    // Queue overflow with the consumer stalled, then drain in order.
    dout_ready = 1'b0;
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    idle(2);
    chk("d.overflow", 32'(ov[0]), 32'd1);
    chk("d.head_stable", 32'(dq[0]), 32'd1);
    chk("d.held", 32'(hd[0]), 32'h03E);
    b0 = got[0].size();
    dout_ready = 1'b1;
    idle(6);
    e = '{1, 2, 3, 4};
    chk_got("d.drain", 0, b0, e);
    chk("d.overflow_sticky", 32'(ov[0]), 32'd1);
    chk("d.empty", 32'(dv[0]), 32'd0);

    // Full queue with simultaneous pop and push.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("e.overflow_cleared", 32'(ov[0]), 32'd0);
    dout_ready = 1'b0;
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    b0 = got[0].size();
    dout_ready = 1'b1;
    send(8'h46);
    idle(6);
    chk("e.no_overflow", 32'(ov[0]), 32'd0);
    e = '{1, 2, 3, 4, 9};
    chk_got("e.order", 0, b0, e);

    // Reset after a release prefix discards it; the next byte is a make.
    b0 = got[0].size();
    send(8'hF0);
    reset = 1'b1;
    cyc(1'b1, 8'h16);
    reset = 1'b0;
    send(8'h45);
    chk("f.held", 32'(hd[0]), 32'h001);
    idle(2);
    e = '{0};
    chk_got("f.make", 0, b0, e);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
